face_point: RTL and testbench

FACE_POINT -- requirements
Module: face_point

---
 rtl/face_point.sv | 203 ++++++++++++++++++++
 tb/tb_face_point.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/face_point.sv
// face_point: computes one face point per quad face of a mesh stored in RAM1.
// For every face f the four referenced vertices are summed per axis, the sums
// are divided by four (arithmetic shift, rounding toward minus infinity) and
// the packed result is written to RAM2 at FP_BASE+f.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             run request, sampled only while idle
//   done              high while the finished state is held
//   err               sticky: a vertex index >= NV was seen during this run
//   RAM1_EN/WE/A/Di   RAM1 read port (WE and Di always 0)
//   RAM1_Do           RAM1 read data, valid the cycle after an enabled read
//   RAM2_EN/WE/A/Di   RAM2 write port
//   RAM2_Do           not used
module face_point #(
  parameter logic [8:0] VERT_BASE = 9'd1,
  parameter logic [8:0] FACE_BASE = 9'd256,
  parameter logic [8:0] FP_BASE   = 9'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic        err,
  output logic        RAM1_EN,
  output logic [3:0]  RAM1_WE,
  output logic [8:0]  RAM1_A,
  output logic [31:0] RAM1_Di,
  input  logic [31:0] RAM1_Do,
  output logic        RAM2_EN,
  output logic [3:0]  RAM2_WE,
  output logic [8:0]  RAM2_A,
  output logic [31:0] RAM2_Di,
  input  logic [31:0] RAM2_Do
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR   = 4'd1;
  localparam logic [3:0] S_HCAP  = 4'd2;
  localparam logic [3:0] S_FACE  = 4'd3;
  localparam logic [3:0] S_V0    = 4'd4;
  localparam logic [3:0] S_V1    = 4'd5;
  localparam logic [3:0] S_V2    = 4'd6;
  localparam logic [3:0] S_V3    = 4'd7;
  localparam logic [3:0] S_LAST  = 4'd8;
  localparam logic [3:0] S_WRITE = 4'd9;
  localparam logic [3:0] S_DONE  = 4'd10;

  logic [3:0]         state;
  logic [7:0]         f;
  logic [7:0]         nv;
  logic [7:0]         nf;
  logic [31:0]        face_word;
  logic signed [11:0] acc_x;
  logic signed [11:0] acc_y;
  logic signed [11:0] acc_z;
  logic               err_flag;

  // Vertex whose data is on RAM1_Do this cycle (read was issued last cycle).
  logic [7:0]         cur_idx;
  logic               idx_bad;
  logic signed [11:0] add_x;
  logic signed [11:0] add_y;
  logic signed [11:0] add_z;
  logic signed [11:0] shr_x;
  logic signed [11:0] shr_y;
  logic signed [11:0] shr_z;
  logic               unused;

  assign unused = ^{RAM2_Do, RAM1_Do[31:30]};

  always_comb begin
    cur_idx = face_word[31:24];
    case (state)
      S_V1:    cur_idx = face_word[7:0];
      S_V2:    cur_idx = face_word[15:8];
      S_V3:    cur_idx = face_word[23:16];
      default: cur_idx = face_word[31:24];
    endcase
  end

  assign idx_bad = (cur_idx >= nv);

  // Out-of-range vertices contribute nothing; coordinates sign-extended to 12 bits.
  assign add_x = idx_bad ? 12'sd0 : {{2{RAM1_Do[29]}}, RAM1_Do[29:20]};
  assign add_y = idx_bad ? 12'sd0 : {{2{RAM1_Do[19]}}, RAM1_Do[19:10]};
  assign add_z = idx_bad ? 12'sd0 : {{2{RAM1_Do[9]}},  RAM1_Do[9:0]};

  assign shr_x = acc_x >>> 2;
  assign shr_y = acc_y >>> 2;
  assign shr_z = acc_z >>> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      f         <= 8'd0;
      nv        <= 8'd0;
      nf        <= 8'd0;
      face_word <= 32'd0;
      acc_x     <= 12'sd0;
      acc_y     <= 12'sd0;
      acc_z     <= 12'sd0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HDR;
            err_flag <= 1'b0;
            f        <= 8'd0;
          end
        end
        S_HDR: state <= S_HCAP;
        S_HCAP: begin
          nv <= RAM1_Do[7:0];
          nf <= RAM1_Do[15:8];
          state <= (RAM1_Do[15:8] == 8'd0) ? S_DONE : S_FACE;
        end
        S_FACE: begin
          acc_x <= 12'sd0;
          acc_y <= 12'sd0;
          acc_z <= 12'sd0;
          state <= S_V0;
        end
        S_V0: begin
          face_word <= RAM1_Do;
          state     <= S_V1;
        end
        S_V1, S_V2, S_V3, S_LAST: begin
          acc_x <= acc_x + add_x;
          acc_y <= acc_y + add_y;
          acc_z <= acc_z + add_z;
          if (idx_bad) err_flag <= 1'b1;
          state <= state + 4'd1;
        end
        S_WRITE: begin
          f     <= f + 8'd1;
          state <= ((f + 8'd1) == nf) ? S_DONE : S_FACE;
        end
        S_DONE: begin
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    RAM1_EN = 1'b0;
    RAM1_A  = 9'd0;
    case (state)
      S_HDR: begin
        RAM1_EN = 1'b1;
        RAM1_A  = 9'd0;
      end
      S_FACE: begin
        RAM1_EN = 1'b1;
        RAM1_A  = FACE_BASE + {1'b0, f};
      end
      // The face word is only being captured this cycle, so take v0 straight
      // from the read data.
      S_V0: begin
        RAM1_EN = 1'b1;
        RAM1_A  = VERT_BASE + {1'b0, RAM1_Do[7:0]};
      end
      S_V1: begin
        RAM1_EN = 1'b1;
        RAM1_A  = VERT_BASE + {1'b0, face_word[15:8]};
      end
      S_V2: begin
        RAM1_EN = 1'b1;
        RAM1_A  = VERT_BASE + {1'b0, face_word[23:16]};
      end
      S_V3: begin
        RAM1_EN = 1'b1;
        RAM1_A  = VERT_BASE + {1'b0, face_word[31:24]};
      end
      default: begin
        RAM1_EN = 1'b0;
        RAM1_A  = 9'd0;
      end
    endcase
  end

  always_comb begin
    RAM2_EN = 1'b0;
    RAM2_WE = 4'h0;
    RAM2_A  = 9'd0;
    RAM2_Di = 32'd0;
    if (state == S_WRITE) begin
      RAM2_EN = 1'b1;
      RAM2_WE = 4'hF;
      RAM2_A  = FP_BASE + {1'b0, f};
      RAM2_Di = {2'b00, shr_x[9:0], shr_y[9:0], shr_z[9:0]};
    end
  end

  assign RAM1_WE = 4'h0;
  assign RAM1_Di = 32'd0;
  assign done    = (state == S_DONE);
  assign err     = err_flag;

endmodule

// File: tb/tb_face_point.sv
// Directed bench for face_point with behavioural RAM1/RAM2 models.
module tb_face_point;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic        err;
  logic        ram1_en;
  logic [3:0]  ram1_we;
  logic [8:0]  ram1_a;
  logic [31:0] ram1_di;
  logic [31:0] ram1_do = 32'd0;
  logic        ram2_en;
  logic [3:0]  ram2_we;
  logic [8:0]  ram2_a;
  logic [31:0] ram2_di;
  logic [31:0] ram2_do = 32'd0;

  logic [31:0] ram1 [0:511];
  logic [31:0] ram2 [0:511];
  int          wr_count = 0;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] SENT = 32'hDEADBEEF;

  face_point dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .err(err),
    .RAM1_EN(ram1_en), .RAM1_WE(ram1_we), .RAM1_A(ram1_a), .RAM1_Di(ram1_di),
    .RAM1_Do(ram1_do),
    .RAM2_EN(ram2_en), .RAM2_WE(ram2_we), .RAM2_A(ram2_a), .RAM2_Di(ram2_di),
    .RAM2_Do(ram2_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram1_en) ram1_do <= ram1[ram1_a];
    if (ram2_en && ram2_we == 4'hF) begin
      ram2[ram2_a] <= ram2_di;
      wr_count <= wr_count + 1;
    end
  end

  function automatic logic [31:0] vert(input int x, input int y, input int z);
    logic [9:0] vx, vy, vz;
    vx = 10'(x);
    vy = 10'(y);
    vz = 10'(z);
    return {2'b00, vx, vy, vz};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ram2();
    for (int i = 0; i < 512; i++) ram2[i] = SENT;
  endtask

  // Raise start and count cycles from the first HDR cycle until done is seen.
  task automatic do_run(output int cyc);
    int n;
    n = 0;
    cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        cyc = n - 1;
        break;
      end
    end
  endtask

  task automatic finish_run();
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int cyc;
  int wr_base;

  initial begin
    for (int i = 0; i < 512; i++) ram1[i] = 32'd0;
    clear_ram2();

    // Base mesh: 4 vertices, faces used by several runs.
    ram1[1] = vert(4, 8, -4);
    ram1[2] = vert(8, 8, -4);
    ram1[3] = vert(8, 0, 0);
    ram1[4] = vert(4, 0, 0);
    ram1[256] = 32'h03020100;
    ram1[257] = 32'h00000000;
    ram1[258] = 32'h01010101;

    // Reset state
    #3;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ram1_en", {31'd0, ram1_en}, 32'd0);
    check("rst_ram2_en", {31'd0, ram2_en}, 32'd0);
    check("rst_ram1_a", {23'd0, ram1_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic single face
    ram1[0] = {16'd0, 8'd1, 8'd4};
    clear_ram2();
    wr_base = wr_count;
    do_run(cyc);
    check("t1_done_cycle", 32'(cyc), 32'd9);
    check("t1_ram2_0", ram2[0], 32'h006013FE);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_writes", 32'(wr_count - wr_base), 32'd1);
    $display("run basic: cycles=%0d ram2[0]=%h err=%0d", cyc, ram2[0], err);
    finish_run();

    // Rounding toward minus infinity
    ram1[256] = 32'h03020100;
    ram1[1] = vert(1, 0, 0);
    ram1[2] = 32'd0;
    ram1[3] = 32'd0;
    ram1[4] = 32'd0;
    clear_ram2();
    do_run(cyc);
    check("round_pos", ram2[0], 32'h00000000);
    $display("run round+1: ram2[0]=%h", ram2[0]);
    finish_run();
    ram1[1] = vert(-1, 0, 0);
    clear_ram2();
    do_run(cyc);
    check("round_neg", ram2[0], 32'h3FF00000);
    $display("run round-1: ram2[0]=%h", ram2[0]);
    finish_run();

    // Restore base vertices
    ram1[1] = vert(4, 8, -4);
    ram1[2] = vert(8, 8, -4);
    ram1[3] = vert(8, 0, 0);
    ram1[4] = vert(4, 0, 0);

    // No faces
    ram1[0] = {16'd0, 8'd0, 8'd4};
    clear_ram2();
    wr_base = wr_count;
    do_run(cyc);
    check("nf0_done_cycle", 32'(cyc), 32'd2);
    check("nf0_writes", 32'(wr_count - wr_base), 32'd0);
    $display("run nf=0: cycles=%0d writes=%0d", cyc, wr_count - wr_base);
    finish_run();

    // Three faces
    ram1[0] = {16'd0, 8'd3, 8'd4};
    clear_ram2();
    wr_base = wr_count;
    do_run(cyc);
    check("nf3_done_cycle", 32'(cyc), 32'd23);
    check("nf3_writes", 32'(wr_count - wr_base), 32'd3);
    check("nf3_ram2_0", ram2[0], 32'h006013FE);
    check("nf3_ram2_1", ram2[1], 32'h004023FC);
    check("nf3_ram2_2", ram2[2], 32'h008023FC);
    check("nf3_ram2_3", ram2[3], SENT);
    $display("run nf=3: cycles=%0d %h %h %h", cyc, ram2[0], ram2[1], ram2[2]);
    finish_run();

    // Out-of-range vertex index
    ram1[0] = {16'd0, 8'd1, 8'd4};
    ram1[256] = 32'h05020100;
    ram1[6] = vert(100, 100, 100);
    clear_ram2();
    do_run(cyc);
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_ram2_0", ram2[0], 32'h005013FE);
    $display("run oor: ram2[0]=%h err=%0d", ram2[0], err);
    finish_run();
    ram1[256] = 32'h03020100;
    clear_ram2();
    do_run(cyc);
    check("oor_err_cleared", {31'd0, err}, 32'd0);
    check("oor_next_ram2_0", ram2[0], 32'h006013FE);
    $display("run after oor: ram2[0]=%h err=%0d", ram2[0], err);

    // start still high from the previous run: must stay in DONE
    wr_base = wr_count;
    repeat (10) @(posedge clk);
    #1;
    check("held_done", {31'd0, done}, 32'd1);
    check("held_writes", 32'(wr_count - wr_base), 32'd0);
    $display("held start: done=%0d writes=%0d", done, wr_count - wr_base);
    @(negedge clk);
    start = 1'b0;
    do_run(cyc);
    check("retrig_done_cycle", 32'(cyc), 32'd9);
    check("retrig_writes", 32'(wr_count - wr_base), 32'd1);
    $display("retrigger: cycles=%0d writes=%0d", cyc, wr_count - wr_base);
    finish_run();

    // Reset during V2 of face 1
    ram1[0] = {16'd0, 8'd3, 8'd4};
    clear_ram2();
    wr_base = wr_count;
    @(negedge clk);
    start = 1'b1;
    repeat (13) @(posedge clk);
    #2;
    check("mid_v2_en", {31'd0, ram1_en}, 32'd1);
    check("mid_v2_a", {23'd0, ram1_a}, 32'd1);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ram1_en", {31'd0, ram1_en}, 32'd0);
    check("mid_rst_ram1_a", {23'd0, ram1_a}, 32'd0);
    check("mid_rst_ram2_en", {31'd0, ram2_en}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_idle_en", {31'd0, ram1_en}, 32'd0);
    check("mid_idle_done", {31'd0, done}, 32'd0);
    check("mid_writes", 32'(wr_count - wr_base), 32'd1);
    check("mid_ram2_0", ram2[0], 32'h006013FE);
    check("mid_ram2_1", ram2[1], SENT);
    $display("mid-run reset: writes=%0d ram2[1]=%h", wr_count - wr_base, ram2[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
